// File: rtl/bcd_pkg.sv
// Shared types and helpers for the streaming binary-to-BCD converter.
// Holds the FSM encoding and compile-time digit/overflow helpers.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam int MAX_DIGITS = 32;

  function automatic logic [4*MAX_DIGITS-1:0] bcd_all_nines(input int d);
    logic [4*MAX_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < d) r[4*i+:4] = 4'h9;
    return r;
  endfunction

  // 1 when some W-bit magnitude exceeds what D digits can show
  function automatic logic bcd_can_ovf(input int w, input int d);
    longint unsigned maxin;
    longint unsigned lim;
    logic fits;
    maxin = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    lim   = 64'd1;
    fits  = 1'b0;
    for (int i = 0; i < d; i++)
      if (!fits) begin
        if (lim > maxin / 64'd10) fits = 1'b1;
        else lim = lim * 64'd10;
      end
    if (!fits && lim > maxin) fits = 1'b1;
    return !fits;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to any digit above 4
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_convert_stream.sv
// Sequential binary-to-BCD converter, one shift per clock, with sign,
// saturation on overflow and a leading-zero blanking mask for OSD text.
module bcd_convert_stream
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5,
  parameter bit SIGNED_EN      = 1'b1
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [INPUT_WIDTH-1:0]      i_Binary,
  input  logic                        i_Signed,
  input  logic                        i_Start,
  output logic                        o_Ready,
  output logic [DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic                        o_Negative,
  output logic                        o_Overflow,
  output logic [DECIMAL_DIGITS-1:0]   o_Blank,
  output logic                        o_DV
);

  localparam int W  = INPUT_WIDTH;
  localparam int D  = DECIMAL_DIGITS;
  localparam int BW = D * 4;
  localparam int CW = $clog2(W + 1);

  localparam logic [4*MAX_DIGITS-1:0] NINES_W = bcd_all_nines(D);
  localparam logic [BW-1:0] NINES     = NINES_W[BW-1:0];
  localparam logic          CAN_OVF   = bcd_can_ovf(W, D);
  localparam logic [D-1:0]  BLANK_RST = ~(D'(1));
  localparam logic [CW-1:0] LAST      = CW'(W - 1);

  bcd_state_t state, state_n;

  logic [W-1:0]  x_q;
  logic          sgn_q;
  logic          neg_q;
  logic [W-1:0]  mag_q;
  logic [BW-1:0] bcd_q;
  logic          ovf_q;
  logic [CW-1:0] cnt_q;

  logic [BW-1:0] adj;
  logic [D-1:0]  blank_n;
  logic          zero_run;
  logic          neg_n;
  logic          ovf_eff;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (bcd_q[4*g+:4]),
      .dout (adj[4*g+:4])
    );
  end

  assign neg_n   = SIGNED_EN && sgn_q && x_q[W-1];
  assign ovf_eff = CAN_OVF && ovf_q;
  assign o_Ready = (state == IDLE);

  // Digit i blanks only while every digit from the top down to i is zero
  always_comb begin
    blank_n  = '0;
    zero_run = 1'b1;
    for (int i = D - 1; i >= 1; i--) begin
      zero_run   = zero_run && (bcd_q[4*i+:4] == 4'd0);
      blank_n[i] = zero_run;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (i_Start) state_n = LOAD;
      LOAD:    state_n = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      x_q        <= '0;
      sgn_q      <= 1'b0;
      neg_q      <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      o_BCD      <= '0;
      o_Negative <= 1'b0;
      o_Overflow <= 1'b0;
      o_Blank    <= BLANK_RST;
      o_DV       <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_Start) begin
            x_q   <= i_Binary;
            sgn_q <= i_Signed;
          end
        end
        LOAD: begin
          neg_q <= neg_n;
          mag_q <= neg_n ? -x_q : x_q;
          bcd_q <= '0;
          ovf_q <= 1'b0;
          cnt_q <= '0;
        end
        SHIFT: begin
          bcd_q <= {adj[BW-2:0], mag_q[W-1]};
          ovf_q <= ovf_q | adj[BW-1];
          mag_q <= {mag_q[W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          o_BCD      <= ovf_eff ? NINES : bcd_q;
          o_Overflow <= ovf_eff;
          o_Negative <= neg_q;
          o_Blank    <= ovf_eff ? '0 : blank_n;
          o_DV       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_stream.sv
// Randomised self-checking bench for bcd_convert_stream (16b/5d and 10b/3d).
// Expected results come from a decimal arithmetic model.
module tb_bcd_convert_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] b16 = '0;
  logic        s16 = 1'b0;
  logic        st16 = 1'b0;
  logic        rdy16, neg16, ovf16, dv16;
  logic [19:0] bcd16;
  logic [4:0]  blank16;

  logic [9:0]  b10 = '0;
  logic        s10 = 1'b0;
  logic        st10 = 1'b0;
  logic        rdy10, neg10, ovf10, dv10;
  logic [11:0] bcd10;
  logic [2:0]  blank10;

  int checks = 0;
  int failures = 0;
  int dvc16 = 0;

  bcd_convert_stream #(
    .INPUT_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED_EN(1'b1)
  ) dut16 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(b16), .i_Signed(s16),
    .i_Start(st16), .o_Ready(rdy16), .o_BCD(bcd16),
    .o_Negative(neg16), .o_Overflow(ovf16), .o_Blank(blank16),
    .o_DV(dv16)
  );

  bcd_convert_stream #(
    .INPUT_WIDTH(10), .DECIMAL_DIGITS(3), .SIGNED_EN(1'b1)
  ) dut10 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(b10), .i_Signed(s10),
    .i_Start(st10), .o_Ready(rdy10), .o_BCD(bcd10),
    .o_Negative(neg10), .o_Overflow(ovf10), .o_Blank(blank10),
    .o_DV(dv10)
  );

  always @(negedge clk) if (dv16) dvc16++;

  task automatic chk(input string tag, input longint unsigned got,
                     input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal model: magnitude, saturation and blanking from plain arithmetic
  task automatic model(input int w, input int d, input longint unsigned x,
                       input bit s, output longint unsigned bcd,
                       output bit neg, output bit ovf,
                       output longint unsigned blank);
    longint unsigned mag, m, p;
    neg = s && x[w-1];
    mag = neg ? ((64'd1 << w) - x) : x;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    ovf = (mag >= p);
    bcd = 0;
    blank = 0;
    if (ovf) begin
      for (int i = 0; i < d; i++) bcd = bcd | (64'd9 << (4*i));
    end else begin
      m = mag;
      for (int i = 0; i < d; i++) begin
        bcd = bcd | ((m % 10) << (4*i));
        m = m / 10;
      end
      p = 10;
      for (int i = 1; i < d; i++) begin
        if (mag < p) blank = blank | (64'd1 << i);
        p = p * 10;
      end
    end
  endtask

  task automatic conv16(input logic [15:0] x, input bit s, input bit inject);
    longint unsigned eb, ebl;
    bit en, eo, got;
    int n;
    model(16, 5, x, s, eb, en, eo, ebl);
    b16 = x; s16 = s; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (dv16) got = 1;
      else if (inject && (n == 3 || n == 10)) begin
        st16 = 1'b1; b16 = 16'd999; s16 = 1'b0;
      end else st16 = 1'b0;
    end
    st16 = 1'b0;
    chk("lat16", n, 18);
    chk("bcd16", bcd16, eb);
    chk("neg16", neg16, en);
    chk("ovf16", ovf16, eo);
    chk("blank16", blank16, ebl);
    chk("rdy16", rdy16, 1);
  endtask

  task automatic conv10(input logic [9:0] x, input bit s);
    longint unsigned eb, ebl;
    bit en, eo, got;
    int n;
    model(10, 3, x, s, eb, en, eo, ebl);
    b10 = x; s10 = s; st10 = 1'b1;
    @(posedge clk); #1;
    st10 = 1'b0;
    n = 0; got = 0;
    while (!got && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (dv10) got = 1;
    end
    chk("lat10", n, 12);
    chk("bcd10", bcd10, eb);
    chk("neg10", neg10, en);
    chk("ovf10", ovf10, eo);
    chk("blank10", blank10, ebl);
  endtask

  initial begin
    int dv_before;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy16, 1);
    chk("rst_bcd", bcd16, 0);
    chk("rst_neg", neg16, 0);
    chk("rst_ovf", ovf16, 0);
    chk("rst_dv", dv16, 0);
    chk("rst_blank", blank16, 5'b11110);
    chk("rst_blank10", blank10, 3'b110);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    conv16(16'hFFFF, 1'b0, 1'b0);
    conv16(16'h8000, 1'b1, 1'b0);
    conv16(16'hFFFF, 1'b1, 1'b0);
    conv16(16'h0000, 1'b0, 1'b0);
    conv16(16'h8000, 1'b0, 1'b0);

    // Ignored starts mid-run, then a back-to-back start on ready
    dv_before = dvc16;
    conv16(16'd12345, 1'b0, 1'b1);
    conv16(16'd777, 1'b0, 1'b0);
    chk("dv_pulses", dvc16 - dv_before, 2);

    conv10(10'd1000, 1'b0);
    conv10(10'd999, 1'b0);
    conv10(10'd1023, 1'b0);
    conv10(10'h200, 1'b1);
    conv10(10'd0, 1'b0);

    // Reset mid-SHIFT aborts the conversion
    @(negedge clk);
    b16 = 16'd54321; s16 = 1'b0; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_bcd", bcd16, 0);
    chk("abort_rdy", rdy16, 1);
    chk("abort_blank", blank16, 5'b11110);
    chk("abort_neg", neg16, 0);
    chk("abort_dv", dv16, 0);
    dv_before = dvc16;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_nodv", dvc16 - dv_before, 0);
    conv16(16'd4321, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++)
      conv16(16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 25; i++)
      conv10(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
